// File: rtl/test_pattern_gen_if.sv
// Pixel stream bundle between the test-pattern source and the scan-out path.
// Ports: out_valid/out_ready handshake, out_sof/out_eol markers, red/green/blue colour.
// master = pixel source (drives everything except out_ready), slave = pixel sink.
interface test_pattern_gen_if #(
  parameter int COLOR_W = 8
);
  logic               out_valid;
  logic               out_ready;
  logic               out_sof;
  logic               out_eol;
  logic [COLOR_W-1:0] red;
  logic [COLOR_W-1:0] green;
  logic [COLOR_W-1:0] blue;

  modport master (
    output out_valid, out_sof, out_eol, red, green, blue,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_sof, out_eol, red, green, blue,
    output out_ready
  );
endinterface

// File: rtl/test_pattern_gen.sv
// Video test-pattern source: raster-ordered RGB stream (rainbow, bars, checker, gradient, solid).
// Latency: one registered output stage; first pixel visible 1 cycle after enable is seen.
// Backpressure: presented pixel is frozen until out_ready; with ready held high, 1 pixel/cycle.
// Ports: clk, rst (sync, active-high), enable, mode, solid_rgb, px (stream master), frame_count.
module test_pattern_gen #(
  parameter int COLOR_W    = 8,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FRAME_W    = 16,
  parameter int HUE_STEP   = 4,
  parameter int FRAME_STEP = 8,
  parameter int SQ_LOG2    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [2:0]           mode,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  test_pattern_gen_if.master   px,
  output logic [FRAME_W-1:0]   frame_count
);

  localparam int XW      = $clog2(H_ACTIVE);
  localparam int YW      = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int HW      = COLOR_W + 3;            // hue range 0 .. 6*2^C-1
  localparam int BAR_LEN = H_ACTIVE / 8;
  localparam int BW      = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1;

  localparam logic [HW:0]        HUE_SPAN = (HW+1)'(6 * (2 ** COLOR_W));
  localparam logic [COLOR_W-1:0] MAX      = '1;

  localparam logic [2:0] MODE_RAINBOW  = 3'd0;
  localparam logic [2:0] MODE_BARS     = 3'd1;
  localparam logic [2:0] MODE_CHECKER  = 3'd2;
  localparam logic [2:0] MODE_GRADIENT = 3'd3;
  localparam logic [2:0] MODE_SOLID    = 3'd4;

  // Generator state describes the NEXT pixel to be loaded into the output
  // register, so it advances on each load rather than on each transfer.
  logic [XW-1:0]      x;
  logic [YW-1:0]      y;
  logic [HW-1:0]      h;
  logic [HW-1:0]      frame_hue;
  logic [BW-1:0]      bar_cnt;
  logic [2:0]         bar_idx;
  logic [2:0]         mode_lat;
  logic [COLOR_W-1:0] gen_frame;   // frame number of the pixel being generated

  // Output register stage
  logic               vld_q;
  logic               sof_q;
  logic               eol_q;
  logic               last_q;      // presented pixel closes the frame
  logic [COLOR_W-1:0] r_q, g_q, b_q;

  logic               load, xfer;
  logic               line_start, at_sof, at_eol, at_last_line;
  logic [2:0]         cur_mode;
  logic [HW-1:0]      hue_px, hue_next, frame_hue_next;
  logic [2:0]         bar_px;
  logic [BW-1:0]      cnt_px;
  logic [2:0]         seg;
  logic [COLOR_W-1:0] frac;
  logic               chk;
  logic [COLOR_W-1:0] pix_r, pix_g, pix_b;

  function automatic logic [HW-1:0] hue_add(input logic [HW-1:0] a, input int step);
    logic [HW:0] sum;
    sum = (HW+1)'(a) + (HW+1)'(step);
    if (sum >= HUE_SPAN) sum = sum - HUE_SPAN;
    return sum[HW-1:0];
  endfunction

  assign xfer         = vld_q && px.out_ready;
  assign load         = enable && (!vld_q || px.out_ready);
  assign line_start   = (x == '0);
  assign at_sof       = line_start && (y == '0);
  assign at_eol       = (x == XW'(H_ACTIVE - 1));
  assign at_last_line = (y == YW'(V_ACTIVE - 1));

  // Mode is sampled only for the first pixel of a frame.
  assign cur_mode = at_sof ? mode : mode_lat;

  // Line-start pixels take the frame hue / first bar directly, so no separate
  // reload cycle is needed at the line boundary.
  assign hue_px         = line_start ? frame_hue : h;
  assign bar_px         = line_start ? 3'd0 : bar_idx;
  assign cnt_px         = line_start ? '0 : bar_cnt;
  assign hue_next       = hue_add(hue_px, HUE_STEP);
  assign frame_hue_next = hue_add(frame_hue, FRAME_STEP);

  assign seg  = hue_px[HW-1:COLOR_W];
  assign frac = hue_px[COLOR_W-1:0];
  assign chk  = (|((x >> SQ_LOG2) & XW'(1))) ^ (|((y >> SQ_LOG2) & YW'(1)));

  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    case (cur_mode)
      MODE_RAINBOW: begin
        case (seg)
          3'd0: begin pix_r = MAX;        pix_g = frac;       pix_b = '0;         end
          3'd1: begin pix_r = MAX - frac; pix_g = MAX;        pix_b = '0;         end
          3'd2: begin pix_r = '0;         pix_g = MAX;        pix_b = frac;       end
          3'd3: begin pix_r = '0;         pix_g = MAX - frac; pix_b = MAX;        end
          3'd4: begin pix_r = frac;       pix_g = '0;         pix_b = MAX;        end
          3'd5: begin pix_r = MAX;        pix_g = '0;         pix_b = MAX - frac; end
          default: begin pix_r = '0; pix_g = '0; pix_b = '0; end
        endcase
      end
      MODE_BARS: begin
        // Bar order white,yellow,cyan,green,magenta,red,blue,black maps to
        // r=~idx[1], g=~idx[2], b=~idx[0].
        pix_r = {COLOR_W{~bar_px[1]}};
        pix_g = {COLOR_W{~bar_px[2]}};
        pix_b = {COLOR_W{~bar_px[0]}};
      end
      MODE_CHECKER: begin
        pix_r = chk ? MAX : '0;
        pix_g = chk ? MAX : '0;
        pix_b = chk ? MAX : '0;
      end
      MODE_GRADIENT: begin
        pix_r = COLOR_W'(x);
        pix_g = COLOR_W'(y);
        pix_b = gen_frame;
      end
      MODE_SOLID: {pix_r, pix_g, pix_b} = solid_rgb;
      default: begin pix_r = '0; pix_g = '0; pix_b = '0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x           <= '0;
      y           <= '0;
      h           <= '0;
      frame_hue   <= '0;
      bar_cnt     <= '0;
      bar_idx     <= 3'd0;
      mode_lat    <= 3'd0;
      gen_frame   <= '0;
      vld_q       <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      last_q      <= 1'b0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      frame_count <= '0;
    end else begin
      if (load) begin
        vld_q    <= 1'b1;
        sof_q    <= at_sof;
        eol_q    <= at_eol;
        last_q   <= at_eol && at_last_line;
        r_q      <= pix_r;
        g_q      <= pix_g;
        b_q      <= pix_b;
        mode_lat <= cur_mode;
        h        <= hue_next;
        if (cnt_px == BW'(BAR_LEN - 1)) begin
          bar_cnt <= '0;
          bar_idx <= bar_px + 3'd1;
        end else begin
          bar_cnt <= cnt_px + BW'(1);
          bar_idx <= bar_px;
        end
        if (at_eol) begin
          x <= '0;
          if (at_last_line) begin
            y         <= '0;
            frame_hue <= frame_hue_next;
            gen_frame <= gen_frame + COLOR_W'(1);
          end else begin
            y <= y + YW'(1);
          end
        end else begin
          x <= x + XW'(1);
        end
      end else if (xfer) begin
        vld_q <= 1'b0;
      end
      // Counts frames as seen downstream: bumps when the last pixel is accepted.
      if (xfer && last_q) frame_count <= frame_count + FRAME_W'(1);
    end
  end

  assign px.out_valid = vld_q;
  assign px.out_sof   = sof_q;
  assign px.out_eol   = eol_q;
  assign px.red       = r_q;
  assign px.green     = g_q;
  assign px.blue      = b_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed bench for test_pattern_gen: 16x4 raster, 8-bit colour, hue step 64,
// frame step 256, 2-pixel checker squares. Accepted pixels are logged at the
// falling edge and compared against hand-computed values.
module tb_test_pattern_gen;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [2:0]  mode;
  logic [23:0] solid_rgb;
  logic [15:0] frame_count;

  test_pattern_gen_if #(.COLOR_W(8)) px ();

  test_pattern_gen #(
    .COLOR_W(8), .H_ACTIVE(16), .V_ACTIVE(4), .FRAME_W(16),
    .HUE_STEP(64), .FRAME_STEP(256), .SQ_LOG2(1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .solid_rgb(solid_rgb), .px(px), .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int en_cyc   = 0;
  int base     = 0;
  int stall_bad = 0;

  logic [25:0] cap_pix[$];   // {sof, eol, r, g, b}
  int          cap_fc[$];
  int          cap_cyc[$];
  logic        hold_prev = 1'b0;
  logic [25:0] held      = '0;
  logic [25:0] ref_pix [200];

  always @(posedge clk) cyc <= cyc + 1;

  // Transfer logger and stall-stability monitor.
  always @(negedge clk) begin
    if (hold_prev && (!px.out_valid ||
        {px.out_sof, px.out_eol, px.red, px.green, px.blue} !== held))
      stall_bad <= stall_bad + 1;
    hold_prev <= px.out_valid && !px.out_ready && !rst;
    held      <= {px.out_sof, px.out_eol, px.red, px.green, px.blue};
    if (px.out_valid && px.out_ready && !rst) begin
      cap_pix.push_back({px.out_sof, px.out_eol, px.red, px.green, px.blue});
      cap_fc.push_back(int'(frame_count));
      cap_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] pix_at(input int i);
    if (base + i < cap_pix.size()) return cap_pix[base + i];
    return 26'bx;
  endfunction

  function automatic logic [23:0] rgb_at(input int i);
    logic [25:0] p;
    p = pix_at(i);
    return p[23:0];
  endfunction

  function automatic logic sof_at(input int i);
    logic [25:0] p;
    p = pix_at(i);
    return p[25];
  endfunction

  function automatic logic eol_at(input int i);
    logic [25:0] p;
    p = pix_at(i);
    return p[24];
  endfunction

  function automatic int fc_at(input int i);
    if (base + i < cap_fc.size()) return cap_fc[base + i];
    return -1;
  endfunction

  function automatic int cyc_at(input int i);
    if (base + i < cap_cyc.size()) return cap_cyc[base + i];
    return -1;
  endfunction

  // Reset the DUT, select a mode and start streaming with ready high.
  task automatic start(input logic [2:0] m);
    px.out_ready = 1'b0;
    enable       = 1'b0;
    rst          = 1'b1;
    mode         = m;
    repeat (2) @(posedge clk);
    #1;
    base         = cap_pix.size();
    rst          = 1'b0;
    enable       = 1'b1;
    px.out_ready = 1'b1;
    en_cyc       = cyc;
  endtask

  // Wait (bounded) until n pixels of the current run have been accepted.
  task automatic wait_cap(input int n, input bit stall, input string tag);
    for (int k = 0; k < 3000 && (cap_pix.size() - base) < n; k++) begin
      @(posedge clk);
      #1;
      if (stall) px.out_ready = 1'($urandom_range(0, 1));
    end
    check({tag, "_count"}, 32'((cap_pix.size() - base) >= n), 32'd1);
  endtask

  localparam logic [23:0] BAR_EXP [8] = '{24'hffffff, 24'hffff00, 24'h00ffff, 24'h00ff00,
                                          24'hff00ff, 24'hff0000, 24'h0000ff, 24'h000000};

  initial begin
    int bad;
    int sb0;
    rst = 1'b1; enable = 1'b0; mode = 3'd0; solid_rgb = '0; px.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(px.out_valid), 32'd0);
    check("rst_sof",   32'(px.out_sof),   32'd0);
    check("rst_eol",   32'(px.out_eol),   32'd0);
    check("rst_rgb",   32'({px.red, px.green, px.blue}), 32'd0);
    check("rst_fc",    32'(frame_count),  32'd0);

    // Rainbow, no stalls, seven frames.
    start(3'd0);
    wait_cap(448, 1'b0, "s1");
    check("s1_latency",  32'(cyc_at(0) - en_cyc), 32'd1);
    check("s1_nobubble", 32'(cyc_at(447) - cyc_at(0)), 32'd447);
    check("s1_p0_sof",   32'(sof_at(0)), 32'd1);
    check("s1_p0",   32'(rgb_at(0)),   32'hff0000);
    check("s1_p5",   32'(rgb_at(5)),   32'hbfff00);
    check("s1_p8",   32'(rgb_at(8)),   32'h00ff00);
    check("s1_p10",  32'(rgb_at(10)),  32'h00ff80);
    check("s1_p15",  32'(rgb_at(15)),  32'h003fff);
    check("s1_p16",  32'(rgb_at(16)),  32'hff0000);
    check("s1_p17",  32'(rgb_at(17)),  32'hff4000);
    check("s2_p64",  32'(rgb_at(64)),  32'hffff00);
    check("s2_p79",  32'(rgb_at(79)),  32'hc000ff);
    check("s2_p80",  32'(rgb_at(80)),  32'hffff00);
    check("s2_p320", 32'(rgb_at(320)), 32'hff00ff);
    check("s2_p323", 32'(rgb_at(323)), 32'hff003f);
    check("s2_p324", 32'(rgb_at(324)), 32'hff0000);
    check("s2_p325", 32'(rgb_at(325)), 32'hff4000);
    check("s2_p384", 32'(rgb_at(384)), 32'hff0000);
    check("s1_fc63",  32'(fc_at(63)),  32'd0);
    check("s1_fc64",  32'(fc_at(64)),  32'd1);
    check("s1_fc447", 32'(fc_at(447)), 32'd6);
    bad = 0;
    for (int i = 0; i < 448; i++) begin
      if (eol_at(i) !== ((i % 16) == 15)) bad++;
      if (sof_at(i) !== ((i % 64) == 0)) bad++;
    end
    check("s1_markers", 32'(bad), 32'd0);
    for (int i = 0; i < 200; i++) ref_pix[i] = pix_at(i);

    // Colour bars, one frame.
    start(3'd1);
    wait_cap(64, 1'b0, "s3");
    for (int yy = 0; yy < 4; yy++) begin
      bad = 0;
      for (int xx = 0; xx < 16; xx++)
        if (rgb_at(yy * 16 + xx) !== BAR_EXP[xx / 2]) bad++;
      check($sformatf("s3_line%0d", yy), 32'(bad), 32'd0);
    end
    check("s3_p2",  32'(rgb_at(2)),  32'hffff00);
    check("s3_p15", 32'(rgb_at(15)), 32'h000000);

    // Checker, then mode change to gradient mid-frame.
    start(3'd2);
    wait_cap(10, 1'b0, "s6b_pre");
    mode = 3'd3;
    wait_cap(66, 1'b0, "s6b");
    check("s4_x0y0", 32'(rgb_at(0)),  32'h000000);
    check("s4_x2y0", 32'(rgb_at(2)),  32'hffffff);
    check("s4_x0y2", 32'(rgb_at(32)), 32'hffffff);
    check("s4_x2y2", 32'(rgb_at(34)), 32'h000000);
    check("s4_x1y1", 32'(rgb_at(17)), 32'h000000);
    check("s6b_p10", 32'(rgb_at(10)), 32'hffffff);
    check("s6b_p40", 32'(rgb_at(40)), 32'hffffff);
    check("s6b_p64_sof", 32'(sof_at(64)), 32'd1);
    check("s6b_p64", 32'(rgb_at(64)), 32'h000001);
    check("s6b_p65", 32'(rgb_at(65)), 32'h010001);

    // Gradient from the start of a run.
    start(3'd3);
    wait_cap(84, 1'b0, "grad");
    check("grad_p37", 32'(rgb_at(37)), 32'h050200);
    check("grad_p83", 32'(rgb_at(83)), 32'h030101);

    // Solid fill, colour resampled per pixel.
    solid_rgb = 24'h123456;
    start(3'd4);
    wait_cap(3, 1'b0, "solid_a");
    solid_rgb = 24'habcdef;
    wait_cap(8, 1'b0, "solid_b");
    check("solid_p1", 32'(rgb_at(1)), 32'h123456);
    check("solid_p7", 32'(rgb_at(7)), 32'habcdef);

    // Reserved mode is black.
    start(3'd5);
    wait_cap(3, 1'b0, "black");
    check("black_p2",  32'(rgb_at(2)), 32'h000000);
    check("black_sof", 32'(sof_at(0)), 32'd1);

    // Random backpressure must reproduce the no-stall stream.
    sb0 = stall_bad;
    start(3'd0);
    wait_cap(200, 1'b1, "s5");
    bad = 0;
    for (int i = 0; i < 200; i++) if (pix_at(i) !== ref_pix[i]) bad++;
    check("s5_stream", 32'(bad), 32'd0);
    check("s5_stable", 32'(stall_bad - sb0), 32'd0);
    check("s5_fc63",   32'(fc_at(63)), 32'd0);
    check("s5_fc64",   32'(fc_at(64)), 32'd1);

    // Enable dropped mid-line with the sink stalled.
    start(3'd0);
    wait_cap(5, 1'b0, "s6a_pre");
    enable = 1'b0;
    px.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("s6a_held_vld", 32'(px.out_valid), 32'd1);
    check("s6a_held_rgb", 32'({px.red, px.green, px.blue}), 32'hbfff00);
    px.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("s6a_idle_vld", 32'(px.out_valid), 32'd0);
    check("s6a_idle_cnt", 32'(cap_pix.size() - base), 32'd6);
    enable = 1'b1;
    wait_cap(16, 1'b0, "s6a");
    check("s6a_p5",  32'(rgb_at(5)),  32'hbfff00);
    check("s6a_p6",  32'(rgb_at(6)),  32'h7fff00);
    check("s6a_p6_sof", 32'(sof_at(6)), 32'd0);
    check("s6a_p15_eol", 32'(eol_at(15)), 32'd1);
    check("s6a_p15", 32'(rgb_at(15)), 32'h003fff);

    // Reset in the middle of the second frame.
    start(3'd0);
    wait_cap(70, 1'b0, "s6c_pre");
    check("s6c_fc_before", 32'(frame_count), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("s6c_vld", 32'(px.out_valid), 32'd0);
    check("s6c_fc",  32'(frame_count),  32'd0);
    rst  = 1'b0;
    base = cap_pix.size();
    wait_cap(1, 1'b0, "s6c");
    check("s6c_sof", 32'(sof_at(0)), 32'd1);
    check("s6c_rgb", 32'(rgb_at(0)), 32'hff0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/test_pattern_gen.md
# test_pattern_gen

Parametrised video test-pattern source generating a raster-ordered pixel stream of RGB values with start-of-frame and end-of-line markers over a valid/ready handshake. It supersedes the free-running colour counter. It adds:
- selectable patterns: animated hue rainbow, colour bars, checkerboard, gradient, solid fill;
- configurable colour depth and active resolution;
- per-frame animation.

It sits ahead of the display timing/scan-out path and feeds pixels whenever downstream accepts them.

## Interface
- COLOR_W, 8: bits per colour channel; MAX = 2^COLOR_W−1.
- H_ACTIVE, 640: pixels per line; must be ≥ 8 and a multiple of 8.
- V_ACTIVE, 480: lines per frame; must be ≥ 1.
- FRAME_W, 16: width of the frame counter.
- HUE_STEP, 4: hue increment per pixel; must be < 6·2^COLOR_W.
- FRAME_STEP, 8: hue offset increment per frame; must be < 6·2^COLOR_W.
- SQ_LOG2, 5: checkerboard square size is 2^SQ_LOG2 pixels.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  permits generation of new pixels.
- mode  in  3  0 rainbow, 1 bars, 2 checker, 3 gradient, 4 solid; 5–7 black.
- solid_rgb  in  3·COLOR_W  fill colour for mode 4, packed as {r,g,b}.
- out_valid  out  1  pixel present.
- out_ready  in  1  downstream accepts the pixel.
- out_sof  out  1  pixel is (x=0, y=0).
- out_eol  out  1  pixel is x=H_ACTIVE−1.
- red, green, blue  out  COLOR_W each  pixel colour.
- frame_count  out  FRAME_W  number of completed frames, modulo 2^FRAME_W.

## Operation
- Position counters: x in 0..H_ACTIVE−1 and y in 0..V_ACTIVE−1, scanned in raster order.
  - Both advance only on a transfer (out_valid && out_ready).
  - x wraps to 0 after H_ACTIVE−1, and y then increments.
  - y wraps to 0 after V_ACTIVE−1, and frame_count then increments, wrapping at 2^FRAME_W.
- Mode latch: mode is captured when the pixel at (0,0) is generated and held for the whole frame. A mid-frame change of mode takes effect at the next frame.
- Hue accumulator h, range 0..6·2^C−1 with C = COLOR_W:
  - At each line start h is loaded with frame_hue; each subsequent pixel adds HUE_STEP.
  - Wrap rule: if the sum is ≥ 6·2^C, subtract 6·2^C once.
  - frame_hue resets to 0 and adds FRAME_STEP at each frame end, using the same wrap rule.
- Mode 0, rainbow: s = h>>C selects the segment and f = h mod 2^C.
  - s=0 → (MAX, f, 0); s=1 → (MAX−f, MAX, 0); s=2 → (0, MAX, f).
  - s=3 → (0, MAX−f, MAX); s=4 → (f, 0, MAX); s=5 → (MAX, 0, MAX−f).
- Mode 1, bars: the bar index increments every H_ACTIVE/8 pixels and resets at line start.
  - Colour order: white, yellow, cyan, green, magenta, red, blue, black.
  - Each colour component is either MAX or 0.
- Mode 2, checker: the pixel is white (all MAX) if ((x>>SQ_LOG2) ^ (y>>SQ_LOG2)) bit 0 is 1, otherwise black.
- Mode 3, gradient: red = x mod 2^C, green = y mod 2^C, blue = frame_count mod 2^C.
- Mode 4, solid: colour = solid_rgb, sampled when each pixel is generated.
- Modes 5–7: black.
- Handshake follows stream rules:
  - Once out_valid is high, all outputs are frozen until a transfer occurs.
  - out_valid never drops without a transfer.
- Enable behaviour:
  - When enable is low, no new pixel is generated and the position is held.
  - A pixel already presented stays valid until accepted.
  - When enable rises again, generation resumes at the held position; there is no frame restart.

## Timing
- Reset values: out_valid=0, out_sof=0, out_eol=0, red=green=blue=0, frame_count=0.
  - Internal state also resets: x=y=0, h=0, frame_hue=0, bar index 0, latched mode 0.
- Output register stage:
  - A new pixel is loaded on a clock edge where enable=1 and either out_valid=0 or a transfer occurs.
  - The output is visible in the following cycle.
- Latency: first out_valid appears 1 cycle after the first edge that sees enable=1 with rst=0; the first pixel is (0,0) with out_sof=1.
- Throughput: with out_ready held high and enable=1, there is one pixel per cycle with no bubbles, including across line and frame boundaries.
- Pixel ordering:
  - out_sof and out_eol are coincident with their pixel.
  - For H_ACTIVE/V_ACTIVE=1 degenerate cases, sof and eol may coincide.
- frame_count updates on the same edge that accepts the last pixel (x=H_ACTIVE−1, y=V_ACTIVE−1).
- Reset mid-frame: on the next edge, all state returns to reset values and any presented pixel is dropped.
- Reset priority: rst overrides enable and out_ready on the same edge.

## Test plan
Bench parameters for all scenarios: H_ACTIVE=16, V_ACTIVE=4, COLOR_W=8, HUE_STEP=64, FRAME_STEP=256.
1. Reset, then enable=1 and out_ready=1 in mode 0.
   - First valid is one cycle after enable, with out_sof=1 and RGB (255,0,0).
   - Pixel 5 (h=320, s=1, f=64) → (191,255,0).
   - out_eol=1 on every 16th pixel; 64 pixels per frame; frame_count=1 after the 64th transfer.
2. Mode 0 across a frame boundary: the second frame's first pixel has h=256 (s=1, f=0) → (255,255,0).
   - Hue wrap check: h values ≥ 1536 wrap correctly.
3. Mode 1: per line, each colour is held for 2 pixels, white first through black last, with the pattern identical on all 4 lines.
4. Mode 2 with SQ_LOG2=1: pixel (0,0) is black, (2,0) white, (0,2) white, (2,2) black.
5. Backpressure: toggle out_ready in a pseudo-random pattern.
   - Outputs stay stable while out_valid=1 and out_ready=0.
   - Captured stream equals the no-stall stream pixel for pixel.
6. Enable/mode/reset edge cases:
   - Drop enable mid-line: the held pixel is still accepted, then no new pixel appears until enable rises, and the position resumes.
   - Change mode mid-frame: the new mode appears only from the next out_sof.
   - Assert rst mid-frame: out_valid=0 next cycle and frame_count=0.
